// File: rtl/y86_dmem_unit.sv
// Y86 memory-stage data memory: icode decode, little-endian DATA_W access, fixed latency, valid/ready.
// Optional macro DMEM_ALIGN_CHECK_EN: treat addresses not aligned to DATA_W/8 as faults.
module y86_dmem_unit #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              m_ready,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error,
  output logic              m_stall
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH_BYTES - NB);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [3:0]         icode_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [3:0]         cur_icode;
  logic [ADDR_W-1:0]  live_addr, cur_addr;
  logic [DATA_W-1:0]  live_wdata, cur_wdata, rd_word;
  logic               is_rd, is_wr, is_mem, misalign, fault, commit, do_write;

  logic [7:0] mem [DEPTH_BYTES];

  // In IDLE the op is still on the inputs; afterwards it lives in the capture registers.
  always_comb begin
    live_addr  = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
    live_wdata = (icode == 4'h8) ? valP : DATA_W'(valA);
    cur_icode  = (state == IDLE) ? icode      : icode_q;
    cur_addr   = (state == IDLE) ? live_addr  : addr_q;
    cur_wdata  = (state == IDLE) ? live_wdata : wdata_q;
    is_rd      = (cur_icode == 4'h5) || (cur_icode == 4'h9) || (cur_icode == 4'hB);
    is_wr      = (cur_icode == 4'h4) || (cur_icode == 4'h8) || (cur_icode == 4'hA);
    is_mem     = is_rd || is_wr;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign   = (cur_addr % ADDR_W'(NB)) != '0;
`else
    misalign   = 1'b0;
`endif
    fault      = is_mem && ((cur_addr > LIMIT) || misalign);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (m_valid) begin
          cnt_next = CNT_W'(LATENCY - 1);
          if (!is_mem || fault || LATENCY == 1) begin
            state_next = DONE;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = DONE;
          cnt_next   = '0;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_rd
      assign rd_word[gi*8 +: 8] = mem[cur_addr[IDX_W-1:0] + IDX_W'(gi)];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      icode_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && m_valid) begin
        icode_q <= icode;
        addr_q  <= live_addr;
        wdata_q <= live_wdata;
      end
      if (commit) begin
        valM       <= (is_rd && !fault) ? rd_word : '0;
        dmem_error <= fault;
      end
    end
  end

  // Gated by rst so a reset discards any write that would have committed on this edge.
  assign do_write = commit && is_wr && !fault && !rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        mem[cur_addr[IDX_W-1:0] + IDX_W'(i)] <= cur_wdata[i*8 +: 8];
      end
    end
  end

  assign m_ready = (state == DONE);
  assign m_stall = m_valid && !m_ready;
endmodule

// File: tb/tb_y86_dmem_unit.sv
// Directed bench for y86_dmem_unit: byte-array reference model feeds a scoreboard checked on each m_ready.
// Build with DMEM_ALIGN_CHECK_EN to expect alignment faults.
module tb_y86_dmem_unit;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk, rst, m_valid;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        m_ready, dmem_error, m_stall;
  logic [63:0] valM;

  y86_dmem_unit #(.DATA_W(64), .ADDR_W(64), .DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .icode(icode), .valA(valA), .valE(valE),
    .valP(valP), .m_ready(m_ready), .valM(valM), .dmem_error(dmem_error), .m_stall(m_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_m [DEPTH];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, output exp_t x);
    logic rd, wr;
    logic [63:0] ad, wd;
    rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    ad = (ic == 4'h9 || ic == 4'hB) ? a : e;
    wd = (ic == 4'h8) ? p : a;
    x.err  = (rd || wr) && ((ad > 64'(DEPTH - 8)) || (ALIGN && ad[2:0] != 3'd0));
    x.lat  = ((rd || wr) && !x.err) ? LAT : 1;
    x.valm = '0;
    if (!x.err && rd)
      for (int i = 0; i < 8; i++) x.valm[i*8 +: 8] = mem_m[int'(ad) + i];
    if (!x.err && wr)
      for (int i = 0; i < 8; i++) mem_m[int'(ad) + i] = wd[i*8 +: 8];
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                        input logic [63:0] p, input string tag);
    exp_t x;
    int   cycles = 0;
    int   stalls = 0;
    logic got = 1'b0;
    model(ic, a, e, p, x);
    sb.push_back(x);
    icode = ic; valA = a; valE = e; valP = p; m_valid = 1'b1;
    #1;
    if (m_stall) stalls++;
    while (!got && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (m_ready) got = 1'b1;
      else if (m_stall) stalls++;
    end
    m_valid = 1'b0;
    check({tag, ":ready_seen"}, 64'(got), 64'd1);
    x = sb.pop_front();
    if (got) begin
      check({tag, ":latency"}, 64'(cycles), 64'(x.lat));
      check({tag, ":stall_cycles"}, 64'(stalls), 64'(x.lat));
      check({tag, ":valM"}, valM, x.valm);
      check({tag, ":dmem_error"}, 64'(dmem_error), 64'(x.err));
    end
    $display("op %s icode=%0h valA=%0h valE=%0h valP=%0h -> valM=%0h err=%0b lat=%0d",
             tag, ic, a, e, p, valM, dmem_error, cycles);
    @(posedge clk); #1;
  endtask

  initial begin
    logic pulsed;
    rst = 1'b1; m_valid = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("reset:m_ready", 64'(m_ready), 64'd0);
    check("reset:valM", valM, 64'd0);
    check("reset:dmem_error", 64'(dmem_error), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pre-zero the whole array through the DUT so model and DUT start identical.
    for (int k = 0; k < DEPTH / 8; k++) run_op(4'h4, 64'd0, 64'(k * 8), 64'd0, "zero");

    // call/ret round trip
    run_op(4'h8, 64'd0, 64'h200, 64'h44, "call");
    run_op(4'h9, 64'h200, 64'd0, 64'd0, "ret");
    check("ret:explicit_valM", valM, 64'h44);

    // Reset in the middle of a write: no m_ready pulse, write discarded, outputs cleared.
    icode = 4'h4; valE = 64'h10; valA = 64'hDEAD; valP = '0; m_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; m_valid = 1'b0;
    #1;
    check("rstbusy:valM", valM, 64'd0);
    check("rstbusy:dmem_error", 64'(dmem_error), 64'd0);
    pulsed = m_ready;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      pulsed = pulsed | m_ready;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      pulsed = pulsed | m_ready;
    end
    check("rstbusy:no_ready_pulse", 64'(pulsed), 64'd0);
    run_op(4'h5, 64'd0, 64'h10, 64'd0, "rstbusy_read");
    check("rstbusy:read_not_dead", valM, 64'd0);

    // Overlapping unaligned writes, then read back at the same addresses.
    for (int k = 0; k < 10; k++) run_op(4'h4, 64'(k + 'h1000), 64'(8'hFF + k), 64'd0, "ovl_wr");
    for (int k = 0; k < 10; k++) run_op(4'h5, 64'd0, 64'(8'hFF + k), 64'd0, "ovl_rd");
    if (!ALIGN) check("ovl:last_0x108", valM, 64'h1009);

    // push/pop pair
    run_op(4'hA, 64'h1122_3344_5566_7788, 64'h300, 64'd0, "pushq");
    run_op(4'hB, 64'h300, 64'd0, 64'd0, "popq");

    // Range boundaries
    run_op(4'h4, 64'hA5A5_0000_1234_5678, 64'(DEPTH - 8), 64'd0, "bound_wr_ok");
    run_op(4'h5, 64'd0, 64'(DEPTH - 8), 64'd0, "bound_rd_ok");
    run_op(4'h5, 64'd0, 64'(DEPTH - 7), 64'd0, "bound_rd_over");
    run_op(4'h5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, "bound_rd_high");
    run_op(4'h4, 64'hBEEF, 64'(DEPTH - 7), 64'd0, "bound_wr_over");
    run_op(4'h5, 64'd0, 64'(DEPTH - 8), 64'd0, "bound_rd_after");

    // Non-memory op must not disturb the array.
    run_op(4'h6, 64'hBAD, 64'h200, 64'hBAD, "opq");
    run_op(4'h9, 64'h200, 64'd0, 64'd0, "opq_ret");

    // Unaligned write: legal without the macro, a fault with it.
    run_op(4'h4, 64'hCAFE_F00D, 64'hFF, 64'd0, "align_wr");
    run_op(4'h5, 64'd0, 64'h100, 64'd0, "align_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
